rcpa_arbiter: RTL and testbench

RCPA_ARBITER -- requirements
Module: rcpa_arbiter

---
 rtl/rcpa_pkg.sv | 12 +
 rtl/rcpa_arbiter_adder.sv | 22 ++
 rtl/rcpa_arbiter.sv | 109 ++++++++++
 tb/tb_rcpa_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcpa_pkg.sv
// Shared types and constants for the round-robin RCPA arbiter.
// Holds the FSM state encoding and the response-counter width.
package rcpa_pkg;

    localparam int unsigned OPCNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rcpa_state_t;

endpackage

// File: rtl/rcpa_arbiter_adder.sv
// nBitRcpa: N-bit ripple-carry adder built from a full-adder chain.
// The final carry-out is not produced; the sum wraps modulo 2^N.
module nBitRcpa #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum
);

    logic [N-1:0] w_c;

    assign w_c[0] = 1'b0;

    for (genvar g = 0; g < N; g++) begin : g_fa
        assign o_sum[g] = i_a[g] ^ i_b[g] ^ w_c[g];
        if (g < N - 1) begin : g_carry
            assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
        end
    end

endmodule

// File: rtl/rcpa_arbiter.sv
// Round-robin arbiter feeding one shared ripple-carry adder into a
// single-entry result register with valid/ready handshakes on both sides.
module rcpa_arbiter
    import rcpa_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*N-1:0]    req_a,
    input  logic [NREQ*N-1:0]    req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N-1:0]         rsp_sum,
    output logic [IDW-1:0]       rsp_id,
    output logic [OPCNT_W-1:0]   op_count,
    output logic                 busy
);

    rcpa_state_t        r_state;
    rcpa_state_t        w_next;
    logic [IDW-1:0]     r_ptr;
    logic [N-1:0]       r_sum;
    logic [IDW-1:0]     r_id;
    logic [OPCNT_W-1:0] r_count;

    logic               w_grant_en;
    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [NREQ-1:0]    w_ready;
    logic               w_transfer;
    logic               w_drain;
    logic [N-1:0]       w_a;
    logic [N-1:0]       w_b;
    logic [N-1:0]       w_sum;

    // A slot opens when the register is empty or is being drained this cycle.
    assign w_grant_en = !rst && ((r_state == IDLE) || rsp_ready);
    assign w_drain    = (r_state == HOLD) && rsp_ready;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_ready = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            int unsigned idx;
            idx = (int'(r_ptr) + j) % NREQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(idx);
            end
        end
        if (w_grant_en && w_found) begin
            w_ready[w_win] = 1'b1;
        end
    end

    assign w_transfer = |w_ready;

    assign w_a = req_a[w_win*N +: N];
    assign w_b = req_b[w_win*N +: N];

    nBitRcpa #(.N(N)) u_adder (
        .i_a  (w_a),
        .i_b  (w_b),
        .o_sum(w_sum)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_transfer)             w_next = HOLD;
            HOLD:    if (rsp_ready && !w_transfer) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_id    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_transfer) begin
                r_sum <= w_sum;
                r_id  <= w_win;
                r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
            end
            if (w_drain) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = (r_state == HOLD);
    assign busy      = (r_state == HOLD);
    assign rsp_sum   = r_sum;
    assign rsp_id    = r_id;
    assign op_count  = r_count;

endmodule

// File: tb/tb_rcpa_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and a
// negedge scoreboard with an independent round-robin/sum model.
module tb_rcpa_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       op_count;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    rcpa_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_sum  (rsp_sum),
        .rsp_id   (rsp_id),
        .op_count (op_count),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard model: predicts grants, counts and queued responses.
    typedef struct packed {
        logic [N-1:0]   sum;
        logic [IDW-1:0] id;
    } rsp_t;

    rsp_t      sb_q[$];
    int        m_ptr   = 0;
    bit        m_hold  = 1'b0;
    logic [15:0] m_count = '0;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        int   win;
        bit   found;
        rsp_t r;
        exp_ready = '0;
        win   = 0;
        found = 1'b0;
        if (!rst && (!m_hold || rsp_ready)) begin
            for (int j = 0; j < NREQ; j++) begin
                int idx;
                idx = (m_ptr + j) % NREQ;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            if (found) exp_ready[win] = 1'b1;
        end
        check("sb_req_ready", 32'(req_ready), 32'(exp_ready));
        check("sb_rsp_valid", 32'(rsp_valid), 32'(m_hold));
        check("sb_busy", 32'(busy), 32'(m_hold));
        check("sb_op_count", 32'(op_count), 32'(m_count));
        if (rst) begin
            sb_q.delete();
            m_ptr   = 0;
            m_hold  = 1'b0;
            m_count = '0;
        end else begin
            if (m_hold && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    r = sb_q.pop_front();
                    check("sb_rsp_sum", 32'(rsp_sum), 32'(r.sum));
                    check("sb_rsp_id", 32'(rsp_id), 32'(r.id));
                end
                m_count = m_count + 16'd1;
            end
            if (found) begin
                r.sum = N'(int'(req_a[win*N +: N]) + int'(req_b[win*N +: N]));
                r.id  = IDW'(win);
                sb_q.push_back(r);
                m_ptr  = (win + 1) % NREQ;
                m_hold = 1'b1;
            end else if (m_hold && rsp_ready) begin
                m_hold = 1'b0;
            end
        end
    end

    typedef struct {
        logic [NREQ-1:0]   valid;
        logic [NREQ*N-1:0] a;
        logic [NREQ*N-1:0] b;
        logic              exp_v;
        logic [IDW-1:0]    exp_id;
        logic [N-1:0]      exp_sum;
    } vec_t;

    vec_t tbl[7];

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        tbl[0] = '{4'b0001, 32'h0000000F, 32'h00000030, 1'b1, 2'd0, 8'h3F};
        tbl[1] = '{4'b0100, 32'h44802211, 32'h01800304, 1'b1, 2'd2, 8'h00};
        tbl[2] = '{4'b1010, 32'hAABBCCDD, 32'h10203040, 1'b1, 2'd1, 8'hFC};
        tbl[3] = '{4'b1000, 32'hFF000000, 32'h01000000, 1'b1, 2'd3, 8'h00};
        tbl[4] = '{4'b1111, 32'h01020304, 32'h10203040, 1'b1, 2'd0, 8'h44};
        tbl[5] = '{4'b0110, 32'h00007F00, 32'h00000100, 1'b1, 2'd1, 8'h80};
        tbl[6] = '{4'b0000, 32'h12345678, 32'h9ABCDEF0, 1'b0, 2'd0, 8'h00};

        tick();
        tick();
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_op_count", 32'(op_count), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b1111;
        #1;
        check("reset_ready_held", 32'(req_ready), 32'd0);
        rst = 1'b0;
        req_valid = '0;

        for (int i = 0; i < 7; i++) begin
            do_reset();
            req_valid = tbl[i].valid;
            req_a     = tbl[i].a;
            req_b     = tbl[i].b;
            rsp_ready = 1'b1;
            tick();
            req_valid = '0;
            check($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                check($sformatf("vec%0d_sum", i), 32'(rsp_sum), 32'(tbl[i].exp_sum));
                check($sformatf("vec%0d_id", i), 32'(rsp_id), 32'(tbl[i].exp_id));
            end
            tick();
            check($sformatf("vec%0d_count", i), 32'(op_count), 32'(tbl[i].exp_v));
            check($sformatf("vec%0d_drained", i), 32'(rsp_valid), 32'd0);
        end

        // Fairness: all requesters valid, continuous drain.
        do_reset();
        req_a     = 32'h40302010;
        req_b     = 32'h04030201;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fair_grant%0d", i), 32'(req_ready), 32'(1 << (i % 4)));
            tick();
            check($sformatf("fair_id%0d", i), 32'(rsp_id), 32'(i % 4));
        end
        req_valid = '0;
        tick();
        check("fair_count", 32'(op_count), 32'd8);

        // Backpressure: hold the result for 5 cycles, then drain and accept together.
        do_reset();
        req_a     = 32'h44332212;
        req_b     = 32'h08070634;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd0);
            check($sformatf("bp_sum%0d", i), 32'(rsp_sum), 32'h46);
            check($sformatf("bp_id%0d", i), 32'(rsp_id), 32'd0);
            check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_reopen_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        check("bp_new_id", 32'(rsp_id), 32'd1);
        check("bp_new_sum", 32'(rsp_sum), 32'h28);
        check("bp_new_valid", 32'(rsp_valid), 32'd1);
        check("bp_count1", 32'(op_count), 32'd1);
        tick();
        check("bp_count2", 32'(op_count), 32'd2);

        // Reset while holding a result moves the pointer back to 0.
        do_reset();
        req_a     = 32'h01010101;
        req_b     = 32'h02020202;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        check("rh_pre_count", 32'(op_count), 32'd1);
        check("rh_pre_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b0;
        req_valid = 4'b0101;
        rst = 1'b1;
        #1;
        check("rh_ready_in_rst", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        check("rh_valid", 32'(rsp_valid), 32'd0);
        check("rh_count", 32'(op_count), 32'd0);
        #1;
        check("rh_lowest_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        check("rh_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        tick();

        // Counter wrap over continuous back-to-back traffic.
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        cyc = 0;
        while (op_count !== 16'hFFFF && cyc < 70000) begin
            tick();
            cyc++;
        end
        check("wrap_reach_ffff", 32'(op_count), 32'h0000FFFF);
        tick();
        check("wrap_zero", 32'(op_count), 32'd0);
        req_valid = '0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
